// File: rtl/dsm_bridge_driver.sv
// Full H-bridge gate driver fed by the ternary delta-sigma code.
// Each leg runs its own dead-time FSM; includes fault latch, bad-code flag and switch counter.
module dsm_bridge_driver #(
   parameter int DT_BITS  = 8,
   parameter int DEAD_CYC = 4,
   parameter int CNT_BITS = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [1:0]          pwm,
   input  logic                enable,
   input  logic                fault,
   output logic                hs_a,
   output logic                ls_a,
   output logic                hs_b,
   output logic                ls_b,
   output logic                fault_lat,
   output logic                err_code,
   output logic [CNT_BITS-1:0] sw_count
);

   localparam logic [1:0] S_OFF  = 2'd0;
   localparam logic [1:0] S_DEAD = 2'd1;
   localparam logic [1:0] S_HIGH = 2'd2;
   localparam logic [1:0] S_LOW  = 2'd3;

   localparam logic [DT_BITS-1:0] DEAD_LD = DT_BITS'(DEAD_CYC);

   logic [1:0]          pwm_q;
   logic                fault_lat_q, fault_lat_d;
   logic                err_q, err_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic [1:0]          st_q [2];
   logic [1:0]          st_d [2];
   logic [DT_BITS-1:0]  dt_q [2];
   logic [DT_BITS-1:0]  dt_d [2];
   logic [1:0]          hs_q, hs_d, ls_q, ls_d;
   logic [1:0]          ent;
   logic [1:0]          tgt_hi;
   logic                run;

   function automatic logic [CNT_BITS-1:0] sat_add(input logic [CNT_BITS-1:0] a,
                                                    input logic [1:0]          inc);
      logic [CNT_BITS:0] s;
      s = {1'b0, a} + (CNT_BITS+1)'(inc);
      return s[CNT_BITS] ? {CNT_BITS{1'b1}} : s[CNT_BITS-1:0];
   endfunction

   always_comb begin
      run         = enable & ~fault_lat_q;
      // Leg A drives high on +1, leg B on -1; 00 and the illegal 10 freewheel low.
      tgt_hi[0]   = (pwm_q == 2'b01);
      tgt_hi[1]   = (pwm_q == 2'b11);
      // Set dominates the enable-low clear.
      fault_lat_d = fault | (fault_lat_q & enable);
      err_d       = err_q | (pwm == 2'b10);
      hs_d        = 2'b00;
      ls_d        = 2'b00;
      ent         = 2'b00;
      for (int l = 0; l < 2; l++) begin
         st_d[l] = st_q[l];
         dt_d[l] = dt_q[l];
         if (!run) begin
            st_d[l] = S_OFF;
         end else begin
            case (st_q[l])
               S_OFF: begin
                  st_d[l] = S_DEAD;
                  dt_d[l] = DEAD_LD;
               end
               S_DEAD: begin
                  // Target is only looked at on the last dead cycle, so reverts never shorten it.
                  if (dt_q[l] <= DT_BITS'(1)) begin
                     ent[l] = 1'b1;
                     if (tgt_hi[l]) begin
                        st_d[l] = S_HIGH;
                        hs_d[l] = 1'b1;
                     end else begin
                        st_d[l] = S_LOW;
                        ls_d[l] = 1'b1;
                     end
                  end else begin
                     dt_d[l] = dt_q[l] - DT_BITS'(1);
                  end
               end
               S_HIGH: begin
                  if (!tgt_hi[l]) begin
                     st_d[l] = S_DEAD;
                     dt_d[l] = DEAD_LD;
                  end else begin
                     hs_d[l] = 1'b1;
                  end
               end
               default: begin
                  if (tgt_hi[l]) begin
                     st_d[l] = S_DEAD;
                     dt_d[l] = DEAD_LD;
                  end else begin
                     ls_d[l] = 1'b1;
                  end
               end
            endcase
         end
      end
      cnt_d = sat_add(cnt_q, {1'b0, ent[0]} + {1'b0, ent[1]});
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pwm_q       <= 2'b00;
         fault_lat_q <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         hs_q        <= 2'b00;
         ls_q        <= 2'b00;
         for (int l = 0; l < 2; l++) begin
            st_q[l] <= S_OFF;
            dt_q[l] <= '0;
         end
      end else begin
         pwm_q       <= pwm;
         fault_lat_q <= fault_lat_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         hs_q        <= hs_d;
         ls_q        <= ls_d;
         for (int l = 0; l < 2; l++) begin
            st_q[l] <= st_d[l];
            dt_q[l] <= dt_d[l];
         end
      end
   end

   assign hs_a      = hs_q[0];
   assign ls_a      = ls_q[0];
   assign hs_b      = hs_q[1];
   assign ls_b      = ls_q[1];
   assign fault_lat = fault_lat_q;
   assign err_code  = err_q;
   assign sw_count  = cnt_q;

endmodule

// File: tb/tb_dsm_bridge_driver.sv
// Directed bench for dsm_bridge_driver plus a short randomized gate-safety sweep.
// The switch counter is narrowed to 4 bits so saturation is reachable quickly.
module tb_dsm_bridge_driver;

   localparam int DTB  = 8;
   localparam int DEAD = 4;
   localparam int CW   = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic [1:0]    pwm;
   logic          enable;
   logic          fault;
   logic          hs_a, ls_a, hs_b, ls_b;
   logic          fault_lat, err_code;
   logic [CW-1:0] sw_count;

   int n_assert = 0;
   int n_fail   = 0;

   dsm_bridge_driver #(.DT_BITS(DTB), .DEAD_CYC(DEAD), .CNT_BITS(CW)) dut (
      .clock     (clock),
      .reset     (reset),
      .pwm       (pwm),
      .enable    (enable),
      .fault     (fault),
      .hs_a      (hs_a),
      .ls_a      (ls_a),
      .hs_b      (hs_b),
      .ls_b      (ls_b),
      .fault_lat (fault_lat),
      .err_code  (err_code),
      .sw_count  (sw_count)
   );

   always #5 clock = ~clock;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {hs_a, ls_a, hs_b, ls_b}
   function automatic logic [3:0] gates();
      return {hs_a, ls_a, hs_b, ls_b};
   endfunction

   initial begin
      logic [1:0] prev_hs [2];
      logic [1:0] prev_ls [2];
      int         zrun [2];
      logic [1:0] cur;

      reset = 1'b1; enable = 1'b0; pwm = 2'b00; fault = 1'b0;
      tick(2);
      chk("reset_gates", 32'(gates()), 32'h0);
      chk("reset_flags", {30'd0, fault_lat, err_code}, 32'h0);
      chk("reset_cnt", 32'(sw_count), 32'h0);

      // Enable with freewheel code: both low sides on after the dead period
      reset = 1'b0; enable = 1'b1;
      tick(4);
      chk("en_dead_gates", 32'(gates()), 32'h0);
      tick(1);
      chk("en_on_gates", 32'(gates()), 32'b0101);
      chk("en_on_cnt", 32'(sw_count), 32'd2);

      // +1: leg A crosses to high side, leg B keeps low side
      pwm = 2'b01;
      tick(2);
      chk("p01_dead_gates", 32'(gates()), 32'b0001);
      tick(3);
      chk("p01_late_dead", 32'(gates()), 32'b0001);
      tick(1);
      chk("p01_on_gates", 32'(gates()), 32'b1001);
      chk("p01_cnt", 32'(sw_count), 32'd3);

      // One-cycle -1 glitch: both legs still sit out a full dead period
      pwm = 2'b11;
      tick(1);
      pwm = 2'b01;
      tick(1);
      chk("glitch_off", 32'(gates()), 32'h0);
      tick(3);
      chk("glitch_dead", 32'(gates()), 32'h0);
      tick(1);
      chk("glitch_back", 32'(gates()), 32'b1001);
      chk("glitch_cnt", 32'(sw_count), 32'd5);

      // Fault pulse while conducting
      fault = 1'b1;
      tick(1);
      chk("fault_lat_set", 32'(fault_lat), 32'd1);
      fault = 1'b0;
      tick(1);
      chk("fault_gates_off", 32'(gates()), 32'h0);
      tick(2);
      chk("fault_lat_hold", 32'(fault_lat), 32'd1);
      chk("fault_hold_gates", 32'(gates()), 32'h0);
      enable = 1'b0;
      tick(1);
      chk("fault_lat_clr", 32'(fault_lat), 32'd0);
      enable = 1'b1;
      tick(4);
      chk("reen_dead", 32'(gates()), 32'h0);
      tick(1);
      chk("reen_on", 32'(gates()), 32'b1001);
      chk("reen_cnt", 32'(sw_count), 32'd7);

      // Set and clear in the same cycle: set wins
      enable = 1'b0; fault = 1'b1;
      tick(1);
      chk("fault_set_wins", 32'(fault_lat), 32'd1);
      fault = 1'b0;
      tick(1);
      chk("fault_clr_after", 32'(fault_lat), 32'd0);
      enable = 1'b1;
      tick(5);
      chk("reen2_on", 32'(gates()), 32'b1001);
      chk("reen2_cnt", 32'(sw_count), 32'd9);

      // Illegal code 10 acts as freewheel and flags
      pwm = 2'b10;
      tick(2);
      chk("err_set", 32'(err_code), 32'd1);
      chk("p10_dead", 32'(gates()), 32'b0001);
      tick(4);
      chk("p10_freewheel", 32'(gates()), 32'b0101);
      chk("p10_cnt", 32'(sw_count), 32'd10);
      pwm = 2'b00;
      tick(3);
      chk("err_sticky", 32'(err_code), 32'd1);
      chk("p00_gates", 32'(gates()), 32'b0101);

      // Drive leg A back and forth until the counter saturates
      for (int r = 0; r < 4; r++) begin
         pwm = 2'b01;
         tick(8);
         pwm = 2'b00;
         tick(8);
      end
      chk("sat_cnt", 32'(sw_count), 32'hF);
      chk("sat_gates", 32'(gates()), 32'b0101);

      // Reset in the middle of a dead period
      pwm = 2'b01;
      tick(3);
      reset = 1'b1;
      tick(1);
      chk("rst_mid_gates", 32'(gates()), 32'h0);
      chk("rst_mid_cnt", 32'(sw_count), 32'h0);
      chk("rst_mid_err", 32'(err_code), 32'h0);
      reset = 1'b0;
      tick(4);
      chk("rst_restart_dead", 32'(gates()), 32'h0);
      tick(1);
      chk("rst_restart_on", 32'(gates()), 32'b1001);
      chk("rst_restart_cnt", 32'(sw_count), 32'd2);

      // Random sweep: no shoot-through, and each gate turn-on follows >= DEAD idle samples
      for (int l = 0; l < 2; l++) begin
         zrun[l]    = 0;
         prev_hs[l] = (l == 0) ? {1'b0, hs_a} : {1'b0, hs_b};
         prev_ls[l] = (l == 0) ? {1'b0, ls_a} : {1'b0, ls_b};
      end
      for (int c = 0; c < 3000; c++) begin
         pwm    = 2'($urandom_range(0, 3));
         enable = ($urandom_range(0, 15) != 0);
         fault  = ($urandom_range(0, 63) == 0);
         reset  = ($urandom_range(0, 255) == 0);
         tick(1);
         if (hs_a & ls_a) chk("overlap_a", 32'b11, 32'b0);
         if (hs_b & ls_b) chk("overlap_b", 32'b11, 32'b0);
         for (int l = 0; l < 2; l++) begin
            cur = (l == 0) ? {hs_a, ls_a} : {hs_b, ls_b};
            if ((cur[1] & ~prev_hs[l][0]) | (cur[0] & ~prev_ls[l][0]))
               chk($sformatf("dead_before_on_%0d", l), 32'(zrun[l] >= DEAD), 32'd1);
            zrun[l]    = (cur == 2'b00) ? zrun[l] + 1 : 0;
            prev_hs[l] = {1'b0, cur[1]};
            prev_ls[l] = {1'b0, cur[0]};
         end
      end
      reset = 1'b0; fault = 1'b0; enable = 1'b1;
      tick(2);
      chk("final_no_overlap", 32'((hs_a & ls_a) | (hs_b & ls_b)), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
